// File: rtl/spio_spinnaker_link_rx_arbiter.sv
`default_nettype none
// ============================================================================
// spio_spinnaker_link_rx_arbiter
// Packet-level round-robin arbiter: NUM_PORTS link rx flit streams -> one deserializer
// Revision: 1.0
// ============================================================================
module spio_spinnaker_link_rx_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_FLITS = 19
) (
  input  logic                   CLK_IN,
  input  logic                   RESET_IN,
  input  logic [7*NUM_PORTS-1:0] IN_DATA_2OF7,
  input  logic [NUM_PORTS-1:0]   IN_VLD,
  output logic [NUM_PORTS-1:0]   IN_RDY,
  output logic [6:0]             flt_data_2of7,
  output logic                   flt_vld,
  input  logic                   flt_rdy,
  output logic [NUM_PORTS-1:0]   GRANT_OUT,
  output logic                   PKT_DONE_OUT,
  output logic                   SYM_ERR_OUT,
  output logic                   LONG_ERR_OUT
);

  localparam int              PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int              CW     = $clog2(MAX_FLITS + 1);
  localparam logic [6:0]      C_EOP  = 7'b110_0000;
  localparam logic [CW-1:0]   C_LAST = CW'(MAX_FLITS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 pkt_done_q, pkt_done_d;
  logic                 sym_err_q, sym_err_d;
  logic                 long_err_q, long_err_d;

  logic [6:0]           w_data;
  logic                 w_vld;
  logic [2:0]           w_ones;
  logic                 w_xfer, w_eop, w_err, w_long, w_end;
  logic                 w_found;
  logic [PW-1:0]        w_pick, w_cand;

  // Round-robin pick: first requesting port at or after rr_q, wrapping upward.
  always_comb begin
    w_found = 1'b0;
    w_pick  = rr_q;
    w_cand  = rr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_cand = PW'((int'(rr_q) + i) % NUM_PORTS);
      if (!w_found && IN_VLD[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Unregistered flit path from the granted port.
  always_comb begin
    w_data = '0;
    w_vld  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) begin
        w_data = IN_DATA_2OF7[7*p +: 7];
        w_vld  = IN_VLD[p];
      end
    end
    w_ones = '0;
    for (int b = 0; b < 7; b++) begin
      w_ones = w_ones + 3'(w_data[b]);
    end
  end

  // Handshakes are masked during reset so an aborted packet loses no flit.
  assign flt_data_2of7 = w_data;
  assign flt_vld       = (state_q == S_BUSY) && w_vld && !RESET_IN;
  assign IN_RDY        = ((state_q == S_BUSY) && !RESET_IN) ? (grant_q & {NUM_PORTS{flt_rdy}})
                                                            : '0;

  assign w_xfer = flt_vld && flt_rdy;
  assign w_eop  = (w_data == C_EOP);
  assign w_err  = (w_ones != 3'd2);
  assign w_long = (count_q == C_LAST) && !w_eop;
  assign w_end  = w_eop || w_err || w_long;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    count_d    = count_q;
    pkt_done_d = 1'b0;
    sym_err_d  = 1'b0;
    long_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          state_d = S_BUSY;
          grant_d = NUM_PORTS'(1) << w_pick;
          gidx_d  = w_pick;
          count_d = '0;
        end
      end
      S_BUSY: begin
        if (w_xfer) begin
          if (w_end) begin
            state_d    = S_IDLE;
            grant_d    = '0;
            count_d    = '0;
            rr_d       = (gidx_q == PW'(NUM_PORTS - 1)) ? '0 : gidx_q + 1'b1;
            pkt_done_d = w_eop;
            sym_err_d  = w_err;
            long_err_d = w_long && !w_err;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_q       <= '0;
      count_q    <= '0;
      pkt_done_q <= 1'b0;
      sym_err_q  <= 1'b0;
      long_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      count_q    <= count_d;
      pkt_done_q <= pkt_done_d;
      sym_err_q  <= sym_err_d;
      long_err_q <= long_err_d;
    end
  end

  assign GRANT_OUT    = grant_q;
  assign PKT_DONE_OUT = pkt_done_q;
  assign SYM_ERR_OUT  = sym_err_q;
  assign LONG_ERR_OUT = long_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spio_spinnaker_link_rx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spio_spinnaker_link_rx_arbiter
// Directed vector table plus packet-level sequences for the rx arbiter
// Revision: 1.0
// ============================================================================
module tb_spio_spinnaker_link_rx_arbiter;

  localparam int         NP  = 4;
  localparam logic [6:0] EOP = 7'b110_0000;
  localparam logic [6:0] VA  = 7'b000_0011;
  localparam logic [6:0] VB  = 7'b000_0101;

  logic            clk = 1'b0;
  logic            rst;
  logic [7*NP-1:0] in_data;
  logic [NP-1:0]   in_vld, in_rdy, grant;
  logic [6:0]      f_data;
  logic            f_vld, f_rdy, done, sym, lng;

  always #5 clk = ~clk;

  spio_spinnaker_link_rx_arbiter #(.NUM_PORTS(NP), .MAX_FLITS(19)) dut (
    .CLK_IN        (clk),
    .RESET_IN      (rst),
    .IN_DATA_2OF7  (in_data),
    .IN_VLD        (in_vld),
    .IN_RDY        (in_rdy),
    .flt_data_2of7 (f_data),
    .flt_vld       (f_vld),
    .flt_rdy       (f_rdy),
    .GRANT_OUT     (grant),
    .PKT_DONE_OUT  (done),
    .SYM_ERR_OUT   (sym),
    .LONG_ERR_OUT  (lng)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic            rst;
    logic [NP-1:0]   vld;
    logic [7*NP-1:0] data;
    logic            rdy;
    logic [NP-1:0]   e_grant;
    logic [NP-1:0]   e_rdy;
    logic            e_vld;
    logic [6:0]      e_data;
    logic            e_done;
    logic            e_sym;
    logic            e_long;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic r, logic [NP-1:0] v, logic [7*NP-1:0] d, logic rd,
                              logic [NP-1:0] eg, logic [NP-1:0] er, logic ev, logic [6:0] ed,
                              logic edn, logic es, logic el);
    vec_t t;
    t.rst = r; t.vld = v; t.data = d; t.rdy = rd;
    t.e_grant = eg; t.e_rdy = er; t.e_vld = ev; t.e_data = ed;
    t.e_done = edn; t.e_sym = es; t.e_long = el;
    return t;
  endfunction

  // k-th two-hot symbol, skipping the EOP code
  function automatic logic [6:0] data_sym(int k);
    int         n = 0;
    logic [6:0] s;
    logic [6:0] r = 7'b000_0011;
    for (int i = 0; i < 7; i++) begin
      for (int j = i + 1; j < 7; j++) begin
        s = 7'b0; s[i] = 1'b1; s[j] = 1'b1;
        if (s != EOP) begin
          if (n == k) r = s;
          n++;
        end
      end
    end
    return r;
  endfunction

  // Source FIFO models and output monitor
  logic [6:0]    src [NP][32];
  int            src_len [NP];
  int            src_idx [NP];
  logic [6:0]    out_q[$];
  logic [6:0]    exp_q[$];
  logic [NP-1:0] gstart_q[$];
  logic [NP-1:0] eg_q[$];
  int            gap_q[$];
  int            xfer_cyc_q[$];
  int            n_done, n_sym, n_long, long_cyc, rdy_bad, zero_run, cyc;
  logic [NP-1:0] sym_grant, long_grant, prev_grant;
  bit            seen_grant;

  task automatic clear_mon();
    out_q.delete(); exp_q.delete(); gstart_q.delete(); eg_q.delete();
    gap_q.delete(); xfer_cyc_q.delete();
    n_done = 0; n_sym = 0; n_long = 0; long_cyc = -1; rdy_bad = 0;
    zero_run = 0; seen_grant = 0; prev_grant = grant;
    sym_grant = '1; long_grant = '1;
    for (int p = 0; p < NP; p++) begin
      src_len[p] = 0;
      src_idx[p] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = '0; f_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive sources for n cycles; inputs change at posedge+1, outputs sampled at negedge.
  task automatic run(int n, bit toggle);
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < NP; p++) begin
        in_vld[p] = (src_idx[p] < src_len[p]);
        in_data[7*p +: 7] = in_vld[p] ? src[p][src_idx[p]] : 7'h00;
      end
      f_rdy = toggle ? ~f_rdy : 1'b1;
      @(negedge clk);
      if (f_vld && f_rdy) begin
        out_q.push_back(f_data);
        xfer_cyc_q.push_back(cyc);
      end
      if (done) n_done++;
      if (sym) begin n_sym++; sym_grant = grant; end
      if (lng) begin n_long++; long_cyc = cyc; long_grant = grant; end
      if (grant != '0 && prev_grant == '0) begin
        gstart_q.push_back(grant);
        if (seen_grant) gap_q.push_back(zero_run);
        seen_grant = 1'b1;
      end
      zero_run = (grant == '0) ? zero_run + 1 : 0;
      if (grant != '0 && in_rdy !== (grant & {NP{f_rdy}})) rdy_bad++;
      prev_grant = grant;
      for (int p = 0; p < NP; p++) begin
        if (in_vld[p] && in_rdy[p]) src_idx[p]++;
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_stream(string name);
    int bad = 0;
    chk({name, " flit count"}, out_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i >= out_q.size()) bad++;
      else if (out_q[i] !== exp_q[i]) bad++;
    end
    chk({name, " flit order"}, bad, 0);
  endtask

  task automatic check_grants(string name);
    int bad = 0;
    chk({name, " grant count"}, gstart_q.size(), eg_q.size());
    foreach (eg_q[i]) begin
      if (i >= gstart_q.size()) bad++;
      else if (gstart_q[i] !== eg_q[i]) bad++;
    end
    chk({name, " grant order"}, bad, 0);
  endtask

  task automatic check_gaps(string name);
    int bad = 0;
    foreach (gap_q[i]) if (gap_q[i] != 1) bad++;
    chk({name, " idle gaps"}, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(1, 4'hF, '0,                1, 4'h0, 4'h0, 0, 7'h0, 0, 0, 0);
    vecs[1]  = mk(1, 4'hF, '0,                1, 4'h0, 4'h0, 0, 7'h0, 0, 0, 0);
    vecs[2]  = mk(0, 4'hF, '0,                1, 4'h0, 4'h0, 0, 7'h0, 0, 0, 0);
    vecs[3]  = mk(0, 4'hF, {21'b0, VA},       1, 4'h1, 4'h1, 1, VA,   0, 0, 0);
    vecs[4]  = mk(0, 4'hF, {21'b0, EOP},      1, 4'h1, 4'h1, 1, EOP,  0, 0, 0);
    vecs[5]  = mk(0, 4'hF, '0,                1, 4'h0, 4'h0, 0, 7'h0, 1, 0, 0);
    vecs[6]  = mk(0, 4'hF, {14'b0, VB, 7'b0}, 0, 4'h2, 4'h0, 1, VB,   0, 0, 0);
    vecs[7]  = mk(0, 4'hF, {14'b0, VB, 7'b0}, 1, 4'h2, 4'h2, 1, VB,   0, 0, 0);
    vecs[8]  = mk(0, 4'hF, {14'b0, EOP, 7'b0},1, 4'h2, 4'h2, 1, EOP,  0, 0, 0);
    vecs[9]  = mk(0, 4'h0, '0,                1, 4'h0, 4'h0, 0, 7'h0, 1, 0, 0);
    vecs[10] = mk(0, 4'h0, '0,                1, 4'h0, 4'h0, 0, 7'h0, 0, 0, 0);

    cyc = 0;
    rst = 1'b1; in_vld = '0; in_data = '0; f_rdy = 1'b1;
    @(posedge clk); #1;

    // Reset hold, first grant two cycles after release, short packets on ports 0 and 1
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; in_vld = vecs[i].vld; in_data = vecs[i].data; f_rdy = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d grant", i),  grant,  vecs[i].e_grant);
      chk($sformatf("vec%0d in_rdy", i), in_rdy, vecs[i].e_rdy);
      chk($sformatf("vec%0d flt_vld", i), f_vld, vecs[i].e_vld);
      if (vecs[i].e_vld) chk($sformatf("vec%0d flt_data", i), f_data, vecs[i].e_data);
      chk($sformatf("vec%0d pkt_done", i), done, vecs[i].e_done);
      chk($sformatf("vec%0d sym_err", i),  sym,  vecs[i].e_sym);
      chk($sformatf("vec%0d long_err", i), lng,  vecs[i].e_long);
      @(posedge clk); #1;
    end

    // Single 11-flit packet on port 2
    do_reset(); clear_mon();
    for (int i = 0; i < 10; i++) src[2][i] = data_sym(i);
    src[2][10] = EOP; src_len[2] = 11;
    for (int i = 0; i < 11; i++) exp_q.push_back(src[2][i]);
    eg_q.push_back(4'b0100);
    run(16, 0);
    check_stream("T2");
    check_grants("T2");
    chk("T2 pkt_done pulses", n_done, 1);
    chk("T2 error pulses", n_sym + n_long, 0);

    // rr pointer now 3: all ports request, service 3,0,1,2
    clear_mon();
    for (int p = 0; p < NP; p++) begin src[p][0] = EOP; src_len[p] = 1; end
    eg_q = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    run(12, 0);
    check_grants("T2 rr");
    check_gaps("T2 rr");
    chk("T2 rr pkt_done pulses", n_done, 4);

    // Round robin with continuous requests on ports 0,1,3
    do_reset(); clear_mon();
    for (int p = 0; p < NP; p++) begin
      if (p != 2) begin
        for (int k = 0; k < 2; k++) begin
          src[p][3*k]   = data_sym(p*4 + k*2);
          src[p][3*k+1] = data_sym(p*4 + k*2 + 1);
          src[p][3*k+2] = EOP;
        end
        src_len[p] = 6;
      end
    end
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < NP; p++) begin
        if (p != 2) for (int f = 0; f < 3; f++) exp_q.push_back(src[p][3*k+f]);
      end
    end
    eg_q = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    run(30, 0);
    check_grants("T3");
    check_gaps("T3");
    chk("T3 gap count", gap_q.size(), 5);
    check_stream("T3");
    chk("T3 pkt_done pulses", n_done, 6);

    // Backpressure on a port 1 packet
    do_reset(); clear_mon();
    for (int i = 0; i < 3; i++) src[1][i] = data_sym(7 + i);
    src[1][3] = EOP; src_len[1] = 4;
    for (int i = 0; i < 4; i++) exp_q.push_back(src[1][i]);
    eg_q.push_back(4'b0010);
    f_rdy = 1'b0;
    run(14, 1);
    check_stream("T4");
    check_grants("T4");
    chk("T4 in_rdy mirrors flt_rdy", rdy_bad, 0);
    chk("T4 pkt_done pulses", n_done, 1);

    // Symbol error on port 0
    do_reset(); clear_mon();
    src[0][0] = data_sym(3); src[0][1] = 7'b000_0111; src_len[0] = 2;
    exp_q = '{src[0][0], src[0][1]};
    run(6, 0);
    check_stream("T5");
    chk("T5 sym_err pulses", n_sym, 1);
    chk("T5 other pulses", n_done + n_long, 0);
    chk("T5 idle after error", sym_grant, 4'b0000);
    clear_mon();
    src[0][0] = EOP; src_len[0] = 1;
    src[1][0] = EOP; src_len[1] = 1;
    eg_q = '{4'b0010, 4'b0001};
    run(8, 0);
    check_grants("T5 rr");

    // Watchdog on a 25-flit packet without EOP from port 3
    do_reset(); clear_mon();
    for (int i = 0; i < 25; i++) begin
      src[3][i] = data_sym(i % 20);
      exp_q.push_back(src[3][i]);
    end
    src_len[3] = 25;
    eg_q = '{4'b1000, 4'b1000};
    run(40, 0);
    check_stream("T6");
    check_grants("T6");
    chk("T6 long_err pulses", n_long, 1);
    chk("T6 long_err timing", long_cyc, (xfer_cyc_q.size() > 18) ? xfer_cyc_q[18] + 1 : -1);
    chk("T6 idle after watchdog", long_grant, 4'b0000);
    chk("T6 other pulses", n_done + n_sym, 0);
    chk("T6 grant held over idle gap", grant, 4'b1000);

    // Reset asserted while the 5th flit is presented
    do_reset(); clear_mon();
    for (int i = 0; i < 25; i++) src[3][i] = data_sym(i % 20);
    src_len[3] = 25;
    run(5, 0);
    chk("T6r flits before reset", out_q.size(), 4);
    rst = 1'b1; in_vld = 4'b1000; in_data[27:21] = src[3][4]; f_rdy = 1'b1;
    @(negedge clk);
    chk("T6r pulses in reset cycle", {29'b0, done, sym, lng}, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_vld = '0;
    @(negedge clk);
    chk("T6r grant after reset", grant, 4'b0000);
    chk("T6r in_rdy after reset", in_rdy, 4'b0000);
    chk("T6r flt_vld after reset", f_vld, 1'b0);
    chk("T6r pulses after reset", {29'b0, done, sym, lng}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("T6r pulses later", {29'b0, done, sym, lng}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
